// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types, defaults and the select-polarity helper for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg_state_t;

    localparam int SEG_DIV_DEF   = 50000;
    localparam int SEG_BLANK_DEF = 100;
    localparam int SEG_MAX_DIG   = 8;

    // Maps an active-high one-hot pattern onto the physical select polarity.
    function automatic logic [SEG_MAX_DIG-1:0] sel_drive(input logic [SEG_MAX_DIG-1:0] onehot,
                                                         input logic                   act_low);
        return act_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/data side and display side of the scan controller; the bench drives master, the DUT is slave.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIG = 8
);
    logic                   en;
    logic                   load;
    logic [4*NUM_DIG-1:0]   data;
    logic [NUM_DIG-1:0]     dig_mask;
    logic [NUM_DIG-1:0]     dp_mask;
    logic [3:0]             hex_out;
    logic [NUM_DIG-1:0]     dig_sel;
    logic                   dp;
    logic                   frame_done;
    logic                   load_pending;

    modport master (
        output en, load, data, dig_mask, dp_mask,
        input  hex_out, dig_sel, dp, frame_done, load_pending
    );

    modport slave (
        input  en, load, data, dig_mask, dp_mask,
        output hex_out, dig_sel, dp, frame_done, load_pending
    );
endinterface

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Slot counter and digit index; both are held at zero while scanning is disabled.
module seg_slot_timer #(
    parameter int NUM_DIG = 8,
    parameter int DIV     = 50000,
    parameter int CNT_W   = $clog2(DIV),
    parameter int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             slot_start,
    output logic             frame_end
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt        = r_cnt;
    assign idx        = r_idx;
    assign slot_start = en && (r_cnt == '0);
    assign frame_end  = en && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a shadow/active buffer pair that
// swaps only at frame boundaries (or immediately while scanning is disabled).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG     = 8,
    parameter int DIV         = SEG_DIV_DEF,
    parameter int BLANK       = SEG_BLANK_DEF,
    parameter int SEL_ACT_LOW = 1
) (
    input logic             clk,
    input logic             rst_n,
    seg_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int DW    = 4 * NUM_DIG;
    localparam logic [NUM_DIG-1:0] SEL_IDLE = (SEL_ACT_LOW != 0) ? '1 : '0;

    generate
        if (NUM_DIG < 1 || NUM_DIG > SEG_MAX_DIG) begin : g_bad_num_dig
            $error("seg_scan_ctrl: NUM_DIG must be in 1..8");
        end
        if (DIV < 2) begin : g_bad_div
            $error("seg_scan_ctrl: DIV must be at least 2");
        end
        if (BLANK < 0 || BLANK >= DIV) begin : g_bad_blank
            $error("seg_scan_ctrl: BLANK must satisfy 0 <= BLANK < DIV");
        end
    endgenerate

    logic [CNT_W-1:0]       w_cnt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_slot_start;
    logic                   w_frame_end;

    seg_slot_timer #(
        .NUM_DIG (NUM_DIG),
        .DIV     (DIV),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .cnt        (w_cnt),
        .idx        (w_idx),
        .slot_start (w_slot_start),
        .frame_end  (w_frame_end)
    );

    logic [DW-1:0]          r_sh_data,  r_act_data;
    logic [NUM_DIG-1:0]     r_sh_dig,   r_act_dig;
    logic [NUM_DIG-1:0]     r_sh_dp,    r_act_dp;
    logic                   r_pending;
    logic [3:0]             r_hex;
    logic [NUM_DIG-1:0]     r_sel;
    logic                   r_dp;
    logic                   r_frame_done;

    seg_state_t             w_state;
    logic                   w_lit;
    logic                   w_commit;
    logic [SEG_MAX_DIG-1:0] w_onehot;
    logic [SEG_MAX_DIG-1:0] w_sel_drv;

    assign w_state   = (int'(w_cnt) < BLANK) ? ST_BLANK : ST_SHOW;
    assign w_lit     = (w_state == ST_SHOW) && r_act_dig[w_idx];
    assign w_onehot  = w_lit ? (SEG_MAX_DIG'(1) << w_idx) : '0;
    assign w_sel_drv = sel_drive(w_onehot, SEL_ACT_LOW != 0);
    // While disabled there is no frame boundary to wait for, so a pending shadow commits at once.
    assign w_commit  = r_pending && (bus.en ? w_frame_end : 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data    <= '0;
            r_sh_dig     <= '0;
            r_sh_dp      <= '0;
            r_act_data   <= '0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_hex        <= '0;
            r_sel        <= SEL_IDLE;
            r_dp         <= 1'b0;
        end else begin
            if (bus.load) begin
                r_sh_data <= bus.data;
                r_sh_dig  <= bus.dig_mask;
                r_sh_dp   <= bus.dp_mask;
            end
            if (w_commit) begin
                r_act_data <= r_sh_data;
                r_act_dig  <= r_sh_dig;
                r_act_dp   <= r_sh_dp;
            end
            // A load landing on the commit cycle keeps the new shadow pending for the next frame.
            if (bus.load) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            r_frame_done <= w_commit;

            if (!bus.en) begin
                r_sel <= SEL_IDLE;
                r_dp  <= 1'b0;
            end else begin
                if (w_slot_start) begin
                    r_hex <= r_act_data[{w_idx, 2'b00} +: 4];
                end
                r_sel <= w_sel_drv[NUM_DIG-1:0];
                r_dp  <= w_lit && r_act_dp[w_idx];
            end
        end
    end

    assign bus.hex_out      = r_hex;
    assign bus.dig_sel      = r_sel;
    assign bus.dp           = r_dp;
    assign bus.frame_done   = r_frame_done;
    assign bus.load_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: NUM_DIG=4, DIV=8, BLANK=2, active-low selects.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] sel;
        logic       dp;
        logic       fd;
    } rec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    rec_t q[$];

    seg_scan_ctrl_if #(.NUM_DIG(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIG     (4),
        .DIV         (8),
        .BLANK       (2),
        .SEL_ACT_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic do_reset(input logic en_v);
        rst_n        = 1'b0;
        bus.en       = en_v;
        bus.load     = 1'b0;
        bus.data     = '0;
        bus.dig_mask = '0;
        bus.dp_mask  = '0;
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic [3:0] dpm);
        bus.data     = d;
        bus.dig_mask = m;
        bus.dp_mask  = dpm;
        bus.load     = 1'b1;
    endtask

    // Expected display for the first n cycles of a frame scanned from a given active buffer.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] m, input logic [3:0] dpm,
                              input bit fd, input int n);
        rec_t r;
        int   cnt;
        int   idx;
        logic lit;
        for (int p = 0; p < n; p++) begin
            cnt   = p % 8;
            idx   = (p / 8) % 4;
            lit   = (cnt >= 2) && m[idx];
            r.hex = d[idx*4 +: 4];
            r.sel = lit ? ~(4'b0001 << idx) : 4'hF;
            r.dp  = lit && dpm[idx];
            r.fd  = fd && (p == 31);
            q.push_back(r);
        end
    endtask

    task automatic test_reset;
        rec_t exp, got;
        do_reset(1'b1);
        checks++;
        if ({bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending} !== 11'b0000_1111_000) begin
            errors++;
            $display("FAIL reset_vals got=%b exp=%b", {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending}, 11'b0000_1111_000);
        end
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        push_frame(16'h1234, 4'hF, 4'hF, 1'b0, 13);
        for (int c = 1; c <= 45; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 3)  do_load(16'h1234, 4'hF, 4'hF);
            if (c == 40) do_load(16'h5555, 4'hF, 4'h0);
        end
        checks++;
        if (bus.load_pending !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_pending got=%b exp=1", bus.load_pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending} !== 11'b0000_1111_000) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending}, 11'b0000_1111_000);
        end
        tick();
        rst_n  = 1'b1;
        bus.en = 1'b0;
        do_load(16'h00E7, 4'hF, 4'h0);
        tick();
        checks++;
        if ({bus.load_pending, bus.frame_done} !== 2'b10) begin
            errors++;
            $display("FAIL reset_load_off got=%b exp=10", {bus.load_pending, bus.frame_done});
        end
        tick();
        checks++;
        if ({bus.load_pending, bus.frame_done} !== 2'b01) begin
            errors++;
            $display("FAIL reset_commit_off got=%b exp=01", {bus.load_pending, bus.frame_done});
        end
        bus.en = 1'b1;
        tick();
        checks++;
        if ({bus.hex_out, bus.dig_sel} !== 8'h7F) begin
            errors++;
            $display("FAIL restart_blank1 got=%h exp=7f", {bus.hex_out, bus.dig_sel});
        end
        tick();
        checks++;
        if (bus.dig_sel !== 4'b1111) begin
            errors++;
            $display("FAIL restart_blank2 got=%b exp=1111", bus.dig_sel);
        end
        tick();
        checks++;
        if (bus.dig_sel !== 4'b1110) begin
            errors++;
            $display("FAIL first_sel got=%b exp=1110", bus.dig_sel);
        end
    endtask

    task automatic test_load;
        rec_t exp, got;
        do_reset(1'b1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        push_frame(16'h1234, 4'hF, 4'h0, 1'b0, 32);
        for (int c = 1; c <= 64; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 20 || c == 33) begin
                checks++;
                if (bus.load_pending !== (c == 20)) begin
                    errors++;
                    $display("FAIL load_pending c=%0d got=%b exp=%b", c, bus.load_pending, (c == 20));
                end
            end
            if (c == 10) do_load(16'h1234, 4'hF, 4'h0);
        end
    endtask

    task automatic test_mask;
        rec_t exp, got;
        do_reset(1'b1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        push_frame(16'hA5C3, 4'b0101, 4'b0001, 1'b0, 32);
        for (int c = 1; c <= 64; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mask_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 5) do_load(16'hA5C3, 4'b0101, 4'b0001);
        end
    endtask

    task automatic test_collision;
        rec_t exp, got;
        do_reset(1'b1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        push_frame(16'h5678, 4'hF, 4'h0, 1'b1, 32);
        push_frame(16'hBEEF, 4'hF, 4'h0, 1'b0, 32);
        for (int c = 1; c <= 96; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL collide_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 32 || c == 64) begin
                checks++;
                if (bus.load_pending !== (c == 32)) begin
                    errors++;
                    $display("FAIL collide_pending c=%0d got=%b exp=%b", c, bus.load_pending, (c == 32));
                end
            end
            if (c == 10) do_load(16'h5678, 4'hF, 4'h0);
            if (c == 31) do_load(16'hBEEF, 4'hF, 4'h0);
        end
    endtask

    task automatic test_enable;
        rec_t exp, got;
        do_reset(1'b1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        push_frame(16'h9ABC, 4'hF, 4'h2, 1'b0, 13);
        for (int c = 1; c <= 45; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 3)  do_load(16'h9ABC, 4'hF, 4'h2);
            if (c == 44) do_load(16'h0F1E, 4'b1011, 4'h0);
        end
        bus.en = 1'b0;
        tick();
        checks++;
        if ({bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending} !== 7'b1111_010) begin
            errors++;
            $display("FAIL en_off_commit got=%b exp=1111010", {bus.dig_sel, bus.dp, bus.frame_done, bus.load_pending});
        end
        tick();
        tick();
        checks++;
        if ({bus.dig_sel, bus.dp, bus.frame_done} !== 6'b1111_00) begin
            errors++;
            $display("FAIL en_off_hold got=%b exp=111100", {bus.dig_sel, bus.dp, bus.frame_done});
        end
        bus.en = 1'b1;
        push_frame(16'h0F1E, 4'b1011, 4'h0, 1'b0, 32);
        for (int c = 1; c <= 32; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL en_restart c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_wrap;
        rec_t exp, got;
        do_reset(1'b1);
        push_frame(16'h0000, 4'h0, 4'h0, 1'b1, 32);
        for (int f = 0; f < 3; f++) push_frame(16'hC0DE, 4'hF, 4'b1010, 1'b0, 32);
        for (int c = 1; c <= 128; c++) begin
            tick();
            exp = q.pop_front();
            got = {bus.hex_out, bus.dig_sel, bus.dp, bus.frame_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap_scan c=%0d got=%h exp=%h", c, got, exp);
            end
            checks++;
            if ($countones(~bus.dig_sel) > 1) begin
                errors++;
                $display("FAIL wrap_onehot c=%0d got=%b exp=at_most_one_low", c, bus.dig_sel);
            end
            if (c == 2) do_load(16'hC0DE, 4'hF, 4'b1010);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.data     = '0;
        bus.dig_mask = '0;
        bus.dp_mask  = '0;
        test_reset();
        test_load();
        test_mask();
        test_collision();
        test_enable();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
